fir_filter_16tap: RTL and testbench
===================================

# fir_filter_16tap

Fixed-length 16-tap direct-form FIR filter on a single 16-bit signed sample stream, producing a registered 32-bit signed result. The block sits in the sample-processing datapath between an upstream sample source, which qualifies each sample with `in_valid`, and downstream logic that samples `out`. It has no output handshake: `out` is a registered value that changes only when a new sample is accepted. The RTL module is named `fir_filter_16tap`.

## Interface
- `DATA_W`, 16: input sample width, signed two's complement.
- `COEF_W`, 16: coefficient width, signed.
- `OUT_W`, 32: output width, signed.
- `COEFFS`, {1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1}: 16 packed signed coefficients h[0]..h[15]. h[0] multiplies the newest sample.
- `clk`, input, 1: single clock, rising-edge active.
- `reset`, input, 1: asynchronous, active-low reset. Sampled at no clock edge.
- `in_valid`, input, 1: high means `in` is a valid sample, accepted at this rising edge.
- `in`, input, DATA_W: signed input sample.
- `out`, output, OUT_W: signed filter result, registered.

## Operation
- State is a delay line x[0]..x[15], each DATA_W signed, plus the `out` register.
- Sample accept, on a rising edge with `in_valid`=1:
  - x[0] <= `in`.
  - x[k] <= x[k-1] for k = 1..15.
  - `out` <= sum over k = 0..15 of h[k]*x'[k], where x' is the post-shift delay line, i.e. x'[0] = `in`.
- With `in_valid`=0 at an edge, the delay line and `out` hold their values. `in` is ignored.
- Arithmetic:
  - Each product is full precision: DATA_W+COEF_W = 32 bits, signed.
  - Products are summed in an accumulator of at least DATA_W+COEF_W+4 = 36 bits.
  - `out` is the low OUT_W bits of the accumulator, so results wrap modulo 2^OUT_W. With the default coefficients no wrap is possible: max |out| = 72*32768 = 2,359,296.
- Coefficients are constants from `COEFFS`. There is no run-time load.
- A fully combinational multiply-add tree feeding `out` is required. No internal pipelining, so latency is fixed.

## Timing
- Reset (`reset`=0):
  - Asynchronously clears all x[k] to 0 and `out` to 0.
  - `out` reads 0 while reset is asserted.
- First edge after `reset` rises: normal operation. A sample with `in_valid`=1 at that edge is accepted.
- Latency: `out` reflects the sample accepted at edge N immediately after edge N, i.e. one register stage.
- Throughput: one sample per clock. `in_valid` may stay high indefinitely or toggle arbitrarily.
- Startup: the first 15 outputs after reset include zero-valued history (zero-padded convolution).
- Reset mid-stream: history is discarded immediately. The next accepted sample sees x[1..15] = 0.
- `in` and `in_valid` must meet setup/hold relative to `clk`. No internal input register is required.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in`=1234 and `in_valid`=1 -> `out`=0 throughout. The delay line stays zero, so the first accepted sample 0 then gives `out`=0.
- Impulse: accept `in`=1, then 16 samples of 0 (`in_valid`=1 each cycle) -> successive `out` = 1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1,0.
- Ramp: accept `in`=0..15 on consecutive cycles -> `out` after the sample 15 edge = 540, after the sample 0 edge = 0, after the sample 1 edge = 1. Deassert `in_valid` -> `out` holds 540.
- Negative full-scale step: accept 16 samples of -32768 -> final `out` = -2,359,296. Each intermediate output is the partial coefficient sum times -32768.
- Valid gaps: impulse `in`=1 with `in_valid` low for 3 cycles between each following zero sample -> same `out` sequence as the impulse test. Values change only on accepted edges.
- Reset mid-stream: after 8 accepted samples of 100, assert `reset` asynchronously -> `out` goes to 0 immediately. Release, then accept `in`=100 -> `out`=100.

Source files
------------

// File: rtl/fir_filter_16tap_if.sv
// Sample-stream interface for the 16-tap FIR: qualified input sample in, registered result out.
// The source side drives in_valid/in; the filter side drives out.
interface fir_filter_16tap_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in;
    logic signed [OUT_W-1:0]  out;

    modport master (
        output in_valid,
        output in,
        input  out
    );

    modport slave (
        input  in_valid,
        input  in,
        output out
    );
endinterface

// File: rtl/fir_filter_16tap.sv
// 16-tap direct-form FIR: one sample per clock, combinational multiply-add tree
// over the post-shift delay line, result registered on each accepted sample.
module fir_filter_16tap #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter logic [16*COEF_W-1:0] COEFFS = {
        16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
        16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1
    }
) (
    input logic             clk,
    input logic             reset,
    fir_filter_16tap_if.slave bus
);
    localparam int TAPS   = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 4;

    logic signed [DATA_W-1:0] x_reg  [TAPS];
    logic signed [DATA_W-1:0] x_next [TAPS];
    logic signed [COEF_W-1:0] h      [TAPS];
    logic signed [PROD_W-1:0] prod   [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  out_reg;
    logic                     acc_unused;

    // h[0] is the leftmost entry of COEFFS and weights the newest sample.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            assign h[gi] = COEFFS[(TAPS-1-gi)*COEF_W +: COEF_W];
            if (gi == 0) begin : g_head
                assign x_next[gi] = bus.in;
            end else begin : g_shift
                assign x_next[gi] = x_reg[gi-1];
            end
            assign prod[gi] = x_next[gi] * h[gi];
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
    end

    // Guard bits above OUT_W are dropped so the result wraps modulo 2^OUT_W.
    assign acc_unused = ^acc[ACC_W-1:OUT_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k] <= '0;
            end
            out_reg <= '0;
        end else if (bus.in_valid) begin
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k] <= x_next[k];
            end
            out_reg <= acc[OUT_W-1:0];
        end
    end

    assign bus.out = out_reg;
endmodule

// File: tb/tb_fir_filter_16tap.sv
// Directed bench for fir_filter_16tap: stimulus pushes hand-computed results into a
// scoreboard queue; a monitor pops and compares on every accepted edge.
module tb_fir_filter_16tap;
    logic clk;
    logic reset;

    fir_filter_16tap_if #(.DATA_W(16), .OUT_W(32)) bus ();

    fir_filter_16tap dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] exp_q [$];
    logic signed [31:0] last_exp;
    int tests;
    int fails;
    int txn;

    localparam int IMP_N = 17;
    localparam int RAMP_N = 16;
    localparam int STEP_N = 16;
    localparam int MID_N = 8;

    logic signed [31:0] imp_exp [IMP_N] = '{1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1,0};
    logic signed [31:0] ramp_exp [RAMP_N] =
        '{0,1,4,10,20,35,56,84,120,164,215,272,334,400,469,540};
    logic signed [31:0] step_exp [STEP_N] =
        '{-32768,-98304,-196608,-327680,-491520,-688128,-917504,-1179648,
          -1441792,-1671168,-1867776,-2031616,-2162688,-2260992,-2326528,-2359296};
    logic signed [31:0] mid_exp [MID_N] = '{100,300,600,1000,1500,2100,2800,3600};

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: out=%0d expected=%0d at %0t", name, act, req, $time);
        end else begin
            $display("[TB] %s: out=%0d ok", name, act);
        end
    endtask

    task automatic send(input logic v, input logic signed [15:0] d,
                        input logic signed [31:0] e);
        @(negedge clk);
        bus.in_valid = v;
        bus.in       = d;
        if (v) exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in       = 16'sd1234;
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    // Monitor: accepted edges pop the scoreboard, idle edges must hold, reset edges read 0.
    initial begin
        logic accepted;
        logic in_reset;
        logic signed [31:0] e;
        last_exp = '0;
        forever begin
            @(posedge clk);
            accepted = bus.in_valid && reset;
            in_reset = !reset;
            #1;
            if (in_reset) begin
                last_exp = '0;
                check("reset_zero", bus.out, 32'sd0);
            end else if (accepted) begin
                txn++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: out=%0d expected=<none>", bus.out);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check($sformatf("txn%0d", txn), bus.out, e);
                end
            end else begin
                check("hold", bus.out, last_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: out=%0d expected=finish", bus.out);
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        txn   = 0;
        // Reset held for two edges while a valid sample is offered.
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in       = 16'sd1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = 16'sd0;
        exp_q.push_back(32'sd0);

        // Impulse response.
        send(1'b1, 16'sd1, imp_exp[0]);
        for (int i = 1; i < IMP_N; i++) send(1'b1, 16'sd0, imp_exp[i]);

        // Ramp, then idle cycles must hold 540.
        for (int i = 0; i < RAMP_N; i++) send(1'b1, 16'(i), ramp_exp[i]);
        send(1'b0, 16'sd999, 32'sd0);
        send(1'b0, -16'sd5, 32'sd0);

        // Negative full-scale step from clean history.
        pulse_reset();
        for (int i = 0; i < STEP_N; i++) send(1'b1, -16'sd32768, step_exp[i]);

        // Impulse with 3-cycle valid gaps.
        pulse_reset();
        send(1'b1, 16'sd1, imp_exp[0]);
        for (int i = 1; i < IMP_N; i++) begin
            repeat (3) send(1'b0, 16'sd777, 32'sd0);
            send(1'b1, 16'sd0, imp_exp[i]);
        end

        // Mid-stream asynchronous reset.
        for (int i = 0; i < MID_N; i++) send(1'b1, 16'sd100, mid_exp[i]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", bus.out, 32'sd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        send(1'b1, 16'sd100, 32'sd100);
        send(1'b0, 16'sd0, 32'sd0);

        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
